// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB responder with a 2^ADDR_W-word register bank and
// programmable wait states.
//   word 0              CTRL, bits [3:0] = wait count for following transfers
//   words 1..DEPTH-3    general read/write storage
//   word DEPTH-2        XFER_CNT, read-only completed-transfer counter
//   word DEPTH-1        ID, read-only, returns ID_VALUE
// Optional feature: define APB_SLV_ERR_EN to answer writes to the two
// read-only words with PSLVERR=1. Without it PSLVERR is constant 0 and such
// writes are silently dropped.
module apb_wait_slave #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hA9B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam int                WAIT_W = 4;
    localparam logic [ADDR_W-1:0] A_CTRL = '0;
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pready_q, pready_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pslverr_q, pslverr_d;

    logic [WAIT_W-1:0]   ctrl_q;
    logic [DATA_W-1:0]   xfer_cnt_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                setup;
    logic                complete;
    logic                commit;
    logic [WAIT_W-1:0]   wait_src;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_write;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_err;
    logic                enter_done;

    assign setup    = PSELx & ~PENABLE;
    // The transfer in DONE completes unless the master has dropped PSELx.
    assign complete = (state_q == S_DONE) & PSELx;
    assign commit   = complete & write_q;

    // A setup accepted in the DONE cycle must see a CTRL write completing at
    // the same edge, so the wait count is forwarded from the pending commit.
    assign wait_src = (commit && addr_q == A_CTRL) ? wdata_q[WAIT_W-1:0] : ctrl_q;

    // While waiting the latched transfer is answered; otherwise the response is
    // for a zero-wait transfer whose setup is on the bus right now.
    assign rd_addr  = (state_q == S_WAIT) ? addr_q  : PADDR;
    assign rd_write = (state_q == S_WAIT) ? write_q : PWRITE;

    // Read mux, with forwarding of a write / counter step landing this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        rd_data = '0;
        if (rd_addr == A_CTRL) begin
            rd_data[WAIT_W-1:0] = wait_src;
        end else if (rd_addr == A_CNT) begin
            rd_data = xfer_cnt_q + DATA_W'(complete);
        end else if (rd_addr == A_ID) begin
            rd_data = ID_VALUE;
        end else if (commit && addr_q == rd_addr) begin
            rd_data = wdata_q;
        end else begin
            rd_data = mem_q[rd_addr];
        end
    end

`ifdef APB_SLV_ERR_EN
    assign rd_err = rd_write & ((rd_addr == A_CNT) | (rd_addr == A_ID));
`else
    assign rd_err = 1'b0;
`endif

    // Next-state and registered-response logic of the transfer FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        enter_done = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Setup in IDLE starts a transfer; setup in DONE starts the
                // next one back-to-back. Anything else returns to IDLE.
                state_d = S_IDLE;
                if (setup) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    if (wait_src == '0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_src;
                    end
                end
            end
            S_WAIT: begin
                if (!PSELx) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d    = S_DONE;
                    cnt_d      = '0;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        pready_d  = enter_done;
        prdata_d  = (enter_done && !rd_write) ? rd_data : '0;
        pslverr_d = enter_done & rd_err;
    end

    // FSM, latched transfer and response registers.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Register bank: commits and the transfer counter update at completion.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q     <= '0;
            xfer_cnt_q <= '0;
            // NOTE: the storage words must read 0 after reset, so the bank is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (complete) begin
                xfer_cnt_q <= xfer_cnt_q + DATA_W'(1);
            end
            if (commit) begin
                if (addr_q == A_CTRL) begin
                    ctrl_q <= wdata_q[WAIT_W-1:0];
                end else if (addr_q < A_CNT) begin
                    mem_q[addr_q] <= wdata_q;
                end
            end
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: a vector table of complete APB
// transfers plus hand-written abort and reset-mid-transfer sequences.
module tb_apb_wait_slave;

`ifdef APB_SLV_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [4:0]  PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int errors = 0;
    int checks = 0;

    apb_wait_slave dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PSELx   (PSELx),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        scramble;   // corrupt PADDR/PWDATA during access
        logic [31:0] exp_rd;     // checked on reads only
        logic        exp_err;
        int          exp_lat;    // access cycles up to and including PREADY
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one transfer starting now (just after a rising edge). Returns the
    // response, the number of access cycles to PREADY and PREADY one cycle on.
    task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                        input logic scr, output logic [31:0] rd, output logic err,
                        output int lat, output logic rdy_after);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        if (scr) begin
            PADDR  = ~a;
            PWDATA = ~wd;
        end
        lat = 1;
        while (!PREADY && lat < 40) begin
            @(posedge PCLK); #1;
            lat++;
        end
        rd  = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        rdy_after = PREADY;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        rdy_after;
        logic        seen;

        //            wr    addr    wdata          scr   exp_rd         exp_err  lat
        vecs[0]  = '{1'b0, 5'd31, 32'h0,         1'b0, 32'hA9B0_0001, 1'b0,    1};
        vecs[1]  = '{1'b0, 5'd30, 32'h0,         1'b0, 32'h0000_0001, 1'b0,    1};
        vecs[2]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0,    1};
        vecs[3]  = '{1'b0, 5'd5,  32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0,    1};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFF_FFF3, 1'b0, 32'h0,         1'b0,    1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 32'h0000_0003, 1'b0,    4};
        vecs[6]  = '{1'b0, 5'd5,  32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0,    4};
        vecs[7]  = '{1'b1, 5'd31, 32'h0000_1234, 1'b0, 32'h0,         ERR_EN,  4};
        vecs[8]  = '{1'b0, 5'd31, 32'h0,         1'b0, 32'hA9B0_0001, 1'b0,    4};
        vecs[9]  = '{1'b1, 5'd30, 32'h0000_0055, 1'b0, 32'h0,         ERR_EN,  4};
        vecs[10] = '{1'b0, 5'd30, 32'h0,         1'b0, 32'h0000_000A, 1'b0,    4};
        vecs[11] = '{1'b1, 5'd29, 32'h0BAD_F00D, 1'b1, 32'h0,         1'b0,    4};
        vecs[12] = '{1'b0, 5'd29, 32'h0,         1'b0, 32'h0BAD_F00D, 1'b0,    4};
        vecs[13] = '{1'b0, 5'd1,  32'h0,         1'b0, 32'h0,         1'b0,    4};
        vecs[14] = '{1'b1, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0,    4};
        vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0,    1};
        vecs[16] = '{1'b1, 5'd0,  32'h0000_000F, 1'b0, 32'h0,         1'b0,    1};
        vecs[17] = '{1'b0, 5'd30, 32'h0,         1'b0, 32'h0000_0011, 1'b0,    16};
        vecs[18] = '{1'b1, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0,    16};

        PRESET  = 1'b1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        check("reset PREADY", 32'(PREADY), 32'h0);
        check("reset PRDATA", PRDATA, 32'h0);
        check("reset PSLVERR", 32'(PSLVERR), 32'h0);

        // Table: 19 completed transfers, XFER_CNT ends at 19, CTRL at 0.
        for (int i = 0; i < NVEC; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].scramble,
                 rd, err, lat, rdy_after);
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d pready_drop", i), 32'(rdy_after), 32'h0);
        end

        // Abort: CTRL=5, write to 7, PSELx dropped after two access cycles.
        xfer(1'b1, 5'd0, 32'd5, 1'b0, rd, err, lat, rdy_after);       // cnt 20
        check("abort ctrl latency", 32'(lat), 32'd1);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'd7; PWDATA = 32'hCAFE_F00D;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        seen = PREADY;
        @(posedge PCLK); #1;
        seen |= PREADY;
        check("abort prdata idle", PRDATA, 32'h0);
        PSELx = 1'b0; PENABLE = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge PCLK); #1;
            seen |= PREADY;
        end
        check("abort pready never", 32'(seen), 32'h0);
        xfer(1'b1, 5'd0, 32'd0, 1'b0, rd, err, lat, rdy_after);       // cnt 21
        check("abort ctrl0 latency", 32'(lat), 32'd6);
        xfer(1'b0, 5'd7, 32'd0, 1'b0, rd, err, lat, rdy_after);       // cnt 22
        check("abort addr7", rd, 32'h0);
        xfer(1'b0, 5'd30, 32'd0, 1'b0, rd, err, lat, rdy_after);      // cnt 23
        check("abort xfer_cnt", rd, 32'd22);

        // Reset in the 2nd access cycle of a 4-wait write to address 9.
        xfer(1'b1, 5'd0, 32'd4, 1'b0, rd, err, lat, rdy_after);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'd9; PWDATA = 32'h9999_9999;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
        check("rst_mid PREADY", 32'(PREADY), 32'h0);
        xfer(1'b0, 5'd9, 32'd0, 1'b0, rd, err, lat, rdy_after);       // cnt 1
        check("rst_mid addr9", rd, 32'h0);
        check("rst_mid latency", 32'(lat), 32'd1);
        xfer(1'b0, 5'd0, 32'd0, 1'b0, rd, err, lat, rdy_after);       // cnt 2
        check("rst_mid ctrl", rd, 32'h0);
        xfer(1'b0, 5'd30, 32'd0, 1'b0, rd, err, lat, rdy_after);
        check("rst_mid xfer_cnt", rd, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_wait_slave.md
# apb_wait_slave

APB responder with a 32-word register bank, programmable wait states and slave-error signalling. It sits on the APB side of the bus, opposite the APB master, and runs in the same `PCLK` domain. It is the standard peripheral endpoint for exercising master stall and error handling. Its behaviour is fully deterministic, so the bus fabric can be verified against it.

## Interface
- `ADDR_W`, 5: address width; bank depth is 2^ADDR_W words.
- `DATA_W`, 32: data width.
- `ID_VALUE`, 32'hA9B0_0001: constant returned from the ID register.
- `PCLK` input 1: clock; all logic on the rising edge.
- `PRESET` input 1: reset, synchronous, active-high.
- `PADDR` input ADDR_W: transfer address.
- `PSELx` input 1: slave select.
- `PENABLE` input 1: access-phase indicator.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PWDATA` input DATA_W: write data.
- `PREADY` output 1: transfer complete (registered).
- `PRDATA` output DATA_W: read data, valid while `PREADY`=1 on a read.
- `PSLVERR` output 1: error response, valid while `PREADY`=1.

## Operation
- Register map:
  - 0 = CTRL. Bits [3:0] hold the wait count; other bits read 0. Read/write.
  - 1..29 = general read/write storage.
  - 30 = XFER_CNT, read-only. Completed-transfer count, 32-bit, wraps 0xFFFF_FFFF→0.
  - 31 = ID, read-only. Returns `ID_VALUE`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE→WAIT on a sampled setup cycle (`PSELx`=1, `PENABLE`=0). Latch address, direction and write data. Load the wait counter from CTRL[3:0].
  - WAIT: decrement the counter each cycle. When it reaches 0, go to DONE and register `PREADY`=1 together with `PRDATA` and `PSLVERR`.
  - DONE: the transfer completes at this edge.
    - A write commits the latched data to the bank.
    - XFER_CNT increments by 1, including for errored transfers.
    - `PREADY` returns to 0.
    - Next state is IDLE. If the current cycle is already a new setup, go directly to WAIT instead (back-to-back transfers).
- Zero wait count: WAIT lasts 0 cycles, so `PREADY` is high in the first access cycle.
- Read data:
  - Reading XFER_CNT returns the value before the increment for that transfer.
  - Outside DONE, `PRDATA`=0.
- Writes to CTRL take effect from the next setup onward. A transfer already in progress keeps its loaded wait count.
- Abort: if `PSELx`=0 during WAIT or DONE, return to IDLE.
  - No commit and no XFER_CNT increment.
  - `PREADY`, `PSLVERR` and `PRDATA` go to 0 at the next edge.
- Protocol violation: `PSELx`=1 with `PENABLE`=1 while in IDLE is ignored and the FSM stays in IDLE. The master times out.
- `PWDATA` and `PADDR` changes during access are ignored; the values latched at setup are used.

## Timing
- Reset values: `PREADY`=0, `PRDATA`=0, `PSLVERR`=0, FSM=IDLE, CTRL=0, XFER_CNT=0, storage words=0.
- Reset mid-transfer: at the edge where `PRESET`=1, no commit and no increment; all state returns to its reset value. Reset has priority over every other event.
- Setup cycle T0 with wait count N: `PREADY` is high in cycle T0+N+1 for exactly one cycle, as long as the master holds `PSELx`.
- Total transfer latency is N+2 cycles (setup plus N+1 access cycles). Maximum is 17 cycles.
- Back-to-back: a setup in the DONE cycle is accepted with no idle cycle. Throughput at N=0 is one transfer per 2 cycles.

## Configuration
- `APB_SLV_ERR_EN`, defined:
  - A write to address 30 or 31 returns `PSLVERR`=1 with `PREADY` and has no effect on the register.
  - Reads never error.
- `APB_SLV_ERR_EN`, undefined:
  - `PSLVERR` is constant 0.
  - Writes to 30/31 complete normally and are silently discarded.

## Test plan
- Reset, then read 31 and 30 → PRDATA 0xA9B00001 then 0x00000001 (one prior transfer); `PSLVERR`=0; `PREADY` in the first access cycle.
- Write 0xDEADBEEF to address 5, read address 5 with CTRL=0 → read returns 0xDEADBEEF; each transfer takes 2 cycles.
- Write CTRL=3, then read address 5 → `PREADY` rises 4 cycles after setup; PRDATA 0xDEADBEEF.
- With `APB_SLV_ERR_EN`: write 0x1234 to address 31 → `PSLVERR`=1 with `PREADY`; a subsequent read of 31 returns 0xA9B00001. Without the macro, `PSLVERR` stays 0.
- CTRL=5, write setup to address 7, drop `PSELx` after 2 access cycles → address 7 stays 0, XFER_CNT unchanged, `PREADY` never rises.
- CTRL=4, write setup to address 9, assert `PRESET` in the 2nd access cycle → address 9 = 0, CTRL = 0, and the next read completes with 0 wait states.
